// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - byte-side output bundle of the serial receiver
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;

  modport master (output rx_data, rx_valid, rx_busy, frame_err);
  modport slave  (input  rx_data, rx_valid, rx_busy, frame_err);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with mid-bit sampling
// Frames are timed from the synchronised start edge; a low stop bit parks the FSM until the line idles.
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic     clk,
  input  logic     rst_,
  input  logic     rx_serial,
  uart_rx_if.master rx_if
);
  localparam int unsigned DIVISOR = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF    = DIVISOR / 2;
  localparam int unsigned CW      = $clog2(DIVISOR);

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  if (DIVISOR < 4) begin : g_div_chk
    $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          busy_q, busy_d;
  logic          rx_s;

  assign rx_s = sync2_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= rx_serial;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          cnt_d   = HALF_M1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rx_s) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = DIV_M1;
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          shift_d[idx_q] = rx_s;
          cnt_d          = DIV_M1;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rx_s) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = S_BREAK;
        end
      end
      S_BREAK: begin
        // Held here so a stuck-low line cannot masquerade as a new start bit.
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign rx_if.rx_data   = data_q;
  assign rx_if.rx_valid  = valid_q;
  assign rx_if.rx_busy   = busy_q;
  assign rx_if.frame_err = ferr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx (DIVISOR 16, HALF 8)
`timescale 1ns/1ps
module tb_uart_rx;
  localparam real BIT_NS = 160.0;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  logic rx_serial = 1'b1;

  uart_rx_if u_if ();

  uart_rx #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .rx_serial (rx_serial),
    .rx_if     (u_if.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_ferr = 0;
  bit both_seen = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (u_if.rx_valid) begin
      n_valid++;
      got_q.push_back(u_if.rx_data);
    end
    if (u_if.frame_err) n_ferr++;
    if (u_if.rx_valid && u_if.frame_err) both_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input real bit_ns, input logic stop_val);
    @(posedge clk);
    #1;
    rx_serial = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      #(bit_ns);
    end
    rx_serial = stop_val;
    #(bit_ns);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] b, input real bit_ns);
    int v0;
    int f0;
    v0 = n_valid;
    f0 = n_ferr;
    send_frame(b, bit_ns, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({tag, "_cnt"}, n_valid, v0 + 1);
    chk({tag, "_data"}, u_if.rx_data, b);
    chk({tag, "_ferr"}, n_ferr, f0);
  endtask

  initial begin
    int v0;
    int f0;
    logic [7:0] b;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", u_if.rx_data, 8'h00);
    chk("rst_valid", u_if.rx_valid, 1'b0);
    chk("rst_busy", u_if.rx_busy, 1'b0);
    chk("rst_ferr", u_if.frame_err, 1'b0);
    rst_ = 1'b1;
    repeat (3) @(posedge clk);

    // Exact-latency frame: line falls 1ns after P0, so T0 = P3 and the strobe follows edge P155.
    fork
      send_frame(8'h55, BIT_NS, 1'b1);
      begin
        @(posedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t0_busy_lo", u_if.rx_busy, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("t0_busy_hi", u_if.rx_busy, 1'b1);
        repeat (151) @(posedge clk);
        @(negedge clk);
        chk("x55_pre_valid", u_if.rx_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("x55_valid", u_if.rx_valid, 1'b1);
        chk("x55_data", u_if.rx_data, 8'h55);
        chk("x55_ferr", u_if.frame_err, 1'b0);
        chk("x55_busy", u_if.rx_busy, 1'b0);
        @(negedge clk);
        chk("x55_valid_1cyc", u_if.rx_valid, 1'b0);
      end
    join

    // Back-to-back stream
    got_q.delete();
    exp_q.delete();
    v0 = n_valid;
    f0 = n_ferr;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    for (int i = 0; i < 12; i++) exp_q.push_back(8'($urandom_range(0, 255)));
    foreach (exp_q[i]) send_frame(exp_q[i], BIT_NS, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("loop_cnt", n_valid, v0 + 14);
    chk("loop_ferr", n_ferr, f0);
    for (int i = 0; i < 14; i++) begin
      b = (i < got_q.size()) ? got_q[i] : 8'hxx;
      chk($sformatf("loop_byte%0d", i), b, exp_q[i]);
    end

    // Glitch of HALF/2 cycles
    v0 = n_valid;
    f0 = n_ferr;
    @(posedge clk);
    #1 rx_serial = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_serial = 1'b1;
    @(negedge clk);
    chk("glitch_busy_win", u_if.rx_busy, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_end", u_if.rx_busy, 1'b0);
    chk("glitch_valid", n_valid, v0);
    chk("glitch_ferr", n_ferr, f0);
    expect_frame("xA5", 8'hA5, BIT_NS);

    // Framing error with the line held low afterwards
    v0 = n_valid;
    f0 = n_ferr;
    send_frame(8'h3C, BIT_NS, 1'b0);
    repeat (48) @(posedge clk);
    @(negedge clk);
    chk("ferr_cnt", n_ferr, f0 + 1);
    chk("ferr_no_valid", n_valid, v0);
    chk("ferr_data_kept", u_if.rx_data, 8'hA5);
    chk("ferr_busy_held", u_if.rx_busy, 1'b1);
    @(posedge clk);
    #1 rx_serial = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("ferr_busy_release", u_if.rx_busy, 1'b0);
    expect_frame("x3C", 8'h3C, BIT_NS);

    // Reset during data bit 4
    v0 = n_valid;
    fork
      send_frame(8'hC3, BIT_NS, 1'b1);
      begin
        @(posedge clk);
        repeat (88) @(posedge clk);
        #2;
        chk("mid_busy_pre", u_if.rx_busy, 1'b1);
        rst_ = 1'b0;
        #1;
        chk("mid_rst_data", u_if.rx_data, 8'h00);
        chk("mid_rst_valid", u_if.rx_valid, 1'b0);
        chk("mid_rst_busy", u_if.rx_busy, 1'b0);
        chk("mid_rst_ferr", u_if.frame_err, 1'b0);
      end
    join
    @(negedge clk);
    rst_ = 1'b1;
    repeat (3) @(posedge clk);
    chk("mid_no_valid", n_valid, v0);
    expect_frame("x81", 8'h81, BIT_NS);

    // Rate skew of +/-2%
    expect_frame("skew_slow", 8'h96, BIT_NS * 1.02);
    expect_frame("skew_fast", 8'h96, BIT_NS * 0.98);

    chk("strobe_exclusive", both_seen, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
